// File: rtl/ball_ctrl.sv
// Pong ball motion engine. The ball advances once per video frame on the vsync
// assertion edge, so its position only changes during vertical blanking.
module ball_ctrl #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_L_X  = 16,
  parameter int PADDLE_R_X  = 616,
  parameter int START_X     = 316,
  parameter int START_Y     = 236,
  parameter int HOLD_FRAMES = 60,
  parameter int WIN_SCORE   = 9,
  parameter int VSYNC_POL   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        serve,
  input  logic [10:0] paddle_l_y,
  input  logic [10:0] paddle_r_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        point,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HOLD = 2'd2,
    S_OVER = 2'd3
  } state_e;

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic VS_ACT = (VSYNC_POL != 0);

  // Geometry is compared at 12 bits so ball + size + speed never wraps.
  localparam logic [11:0] SPD_12    = 12'(SPEED);
  localparam logic [11:0] SIZE_12   = 12'(BALL_SIZE);
  localparam logic [11:0] PAD_H_12  = 12'(PADDLE_H);
  localparam logic [11:0] H_RES_12  = 12'(H_RES);
  localparam logic [11:0] Y_MAX_12  = 12'(V_RES - BALL_SIZE);
  localparam logic [11:0] L_FACE_12 = 12'(PADDLE_L_X + PADDLE_W);
  localparam logic [11:0] R_FACE_12 = 12'(PADDLE_R_X);

  localparam logic [10:0] START_X_11 = 11'(START_X);
  localparam logic [10:0] START_Y_11 = 11'(START_Y);
  localparam logic [10:0] Y_MAX_11   = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0] L_STOP_11  = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic [10:0] R_STOP_11  = 11'(PADDLE_R_X - BALL_SIZE);
  localparam logic [3:0]  WIN_4      = 4'(WIN_SCORE);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  state_e            state_q, state_d;
  logic [10:0]       x_q, x_d, y_q, y_d;
  logic              dir_x_q, dir_x_d;   // 1 = right
  logic              dir_y_q, dir_y_d;   // 1 = down
  logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
  logic              point_q, point_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              vs_q;

  logic        tick;
  logic [11:0] x_w, y_w, nx, ny, pl_w, pr_w;
  logic        ov_l, ov_r, hit_l, hit_r, miss_l, miss_r, win;

  assign tick = (vsync == VS_ACT) && (vs_q != VS_ACT);

  assign x_w  = {1'b0, x_q};
  assign y_w  = {1'b0, y_q};
  assign pl_w = {1'b0, paddle_l_y};
  assign pr_w = {1'b0, paddle_r_y};
  assign nx   = dir_x_q ? x_w + SPD_12 : x_w - SPD_12;
  assign ny   = dir_y_q ? y_w + SPD_12 : y_w - SPD_12;

  assign ov_l = (y_w + SIZE_12 > pl_w) && (y_w < pl_w + PAD_H_12);
  assign ov_r = (y_w + SIZE_12 > pr_w) && (y_w < pr_w + PAD_H_12);

  assign hit_l  = !dir_x_q && (x_w >= L_FACE_12) && (nx <= L_FACE_12) && ov_l;
  assign hit_r  = dir_x_q && (x_w + SIZE_12 <= R_FACE_12) &&
                  (nx + SIZE_12 >= R_FACE_12) && ov_r;
  assign miss_l = !dir_x_q && (x_w < SPD_12);
  assign miss_r = (x_w + SIZE_12 + SPD_12 > H_RES_12);
  assign win    = (score_l_q == WIN_4) || (score_r_q == WIN_4);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    hold_d    = hold_q;
    point_d   = 1'b0;

    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          x_d = START_X_11;
          y_d = START_Y_11;
          if (serve) state_d = S_PLAY;
        end

        S_PLAY: begin
          if (dir_y_q) begin
            if (ny >= Y_MAX_12) begin
              y_d     = Y_MAX_11;
              dir_y_d = 1'b0;
            end else begin
              y_d = ny[10:0];
            end
          end else if (y_w < SPD_12) begin
            y_d     = '0;
            dir_y_d = 1'b1;
          end else begin
            y_d = ny[10:0];
          end

          // Misses override the vertical result: the ball re-serves from centre.
          if (miss_l) begin
            score_r_d = (score_r_q < WIN_4) ? score_r_q + 4'd1 : WIN_4;
            point_d   = 1'b1;
            dir_x_d   = 1'b0;
            x_d       = START_X_11;
            y_d       = START_Y_11;
            hold_d    = '0;
            state_d   = S_HOLD;
          end else if (miss_r) begin
            score_l_d = (score_l_q < WIN_4) ? score_l_q + 4'd1 : WIN_4;
            point_d   = 1'b1;
            dir_x_d   = 1'b1;
            x_d       = START_X_11;
            y_d       = START_Y_11;
            hold_d    = '0;
            state_d   = S_HOLD;
          end else if (hit_l) begin
            x_d     = L_STOP_11;
            dir_x_d = 1'b1;
          end else if (hit_r) begin
            x_d     = R_STOP_11;
            dir_x_d = 1'b0;
          end else begin
            x_d = nx[10:0];
          end
        end

        S_HOLD: begin
          if (hold_q == HOLD_LAST) state_d = win ? S_OVER : S_PLAY;
          else                     hold_d  = hold_q + 1'b1;
        end

        S_OVER: begin
          if (serve) begin
            score_l_d = '0;
            score_r_d = '0;
            dir_x_d   = 1'b1;
            dir_y_d   = 1'b1;
            state_d   = S_PLAY;
          end
        end

        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= START_X_11;
      y_q       <= START_Y_11;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      score_l_q <= '0;
      score_r_q <= '0;
      point_q   <= 1'b0;
      hold_q    <= '0;
      vs_q      <= !VS_ACT;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      point_q   <= point_d;
      hold_q    <= hold_d;
      vs_q      <= vsync;
    end
  end

  assign ball_x  = x_q;
  assign ball_y  = y_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign point   = point_q;
  assign state   = state_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: frame-level reference model, directed table, corner
// sequences for bounces, paddle hits, scoring, game-over and async reset.
module tb_ball_ctrl;

  localparam int H = 640, V = 480, B = 8, SPD = 2, PW = 8, PH = 64;
  localparam int PLX = 16, PRX = 616, SX = 316, SY = 236, HOLDF = 60, WIN = 9;

  logic        clk = 1'b0, rst_n = 1'b1, vsync = 1'b1, serve = 1'b0;
  logic [10:0] paddle_l_y = 11'd400, paddle_r_y = 11'd400;
  logic [10:0] ball_x, ball_y;
  logic [3:0]  score_l, score_r;
  logic        point;
  logic [1:0]  state;

  ball_ctrl dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .serve(serve),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
    .point(point), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Game as seen once per frame; st: 0 idle, 1 play, 2 hold, 3 over.
  typedef struct {
    int x, y, dx, dy, sl, sr, st, hc, pt;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t reset_model();
    mdl_t r;
    r = '{x: SX, y: SY, dx: 1, dy: 1, sl: 0, sr: 0, st: 0, hc: 0, pt: 0};
    return r;
  endfunction

  function automatic bit overlaps(int by, int py);
    return (by + B > py) && (by < py + PH);
  endfunction

  function automatic mdl_t step(mdl_t c, bit sv, int pl, int pr);
    mdl_t n;
    int nx, ny, lface;
    n     = c;
    n.pt  = 0;
    lface = PLX + PW;
    nx    = c.x + SPD * c.dx;
    ny    = c.y + SPD * c.dy;
    case (c.st)
      0: if (sv) n.st = 1;
      1: begin
        if (c.dy > 0) begin
          if (ny >= V - B) begin n.y = V - B; n.dy = -1; end
          else n.y = ny;
        end else begin
          if (c.y < SPD) begin n.y = 0; n.dy = 1; end
          else n.y = ny;
        end
        if (c.dx < 0 && c.x < SPD) begin
          n.sr = (c.sr + 1 > WIN) ? WIN : c.sr + 1;
          n.pt = 1; n.dx = -1; n.st = 2; n.hc = 0; n.x = SX; n.y = SY;
        end else if (c.x + B + SPD > H) begin
          n.sl = (c.sl + 1 > WIN) ? WIN : c.sl + 1;
          n.pt = 1; n.dx = 1; n.st = 2; n.hc = 0; n.x = SX; n.y = SY;
        end else if (c.dx < 0 && c.x >= lface && nx <= lface && overlaps(c.y, pl)) begin
          n.x = lface; n.dx = 1;
        end else if (c.dx > 0 && c.x + B <= PRX && nx + B >= PRX && overlaps(c.y, pr)) begin
          n.x = PRX - B; n.dx = -1;
        end else begin
          n.x = nx;
        end
      end
      2: begin
        n.hc = c.hc + 1;
        if (n.hc == HOLDF) n.st = (c.sl == WIN || c.sr == WIN) ? 3 : 1;
      end
      default: if (sv) begin
        n.sl = 0; n.sr = 0; n.dx = 1; n.dy = 1; n.st = 1;
      end
    endcase
    return n;
  endfunction

  function automatic int clampp(int v);
    return (v < 0) ? 0 : ((v > 2047) ? 2047 : v);
  endfunction

  function automatic int far_pad(int y);
    return (y < 240) ? 400 : 0;
  endfunction

  function automatic int track(int y);
    return clampp(y - 28);
  endfunction

  // One video frame: assert vsync, compare at the tick edge, then release.
  task automatic frame_t(bit sv, int pl, int pr, int lo, int hi);
    mdl_t e;
    e = step(m, sv, pl, pr);
    @(negedge clk);
    serve      = sv;
    paddle_l_y = 11'(pl);
    paddle_r_y = 11'(pr);
    vsync      = 1'b0;
    #1;
    check("pre_edge_x", ball_x, m.x);
    check("pre_edge_state", state, m.st);
    @(posedge clk);
    #1;
    m = e;
    check("x", ball_x, m.x);
    check("y", ball_y, m.y);
    check("state", state, m.st);
    check("score_l", score_l, m.sl);
    check("score_r", score_r, m.sr);
    check("point", point, m.pt);
    @(posedge clk);
    #1;
    check("point_clear", point, 0);
    repeat (lo) @(negedge clk);
    vsync = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic fr(bit sv, int pl, int pr);
    frame_t(sv, pl, pr, $urandom_range(1, 3), $urandom_range(1, 3));
  endtask

  typedef struct {
    bit sv;
    int ex, ey, est;
  } vec_t;

  initial begin
    vec_t tbl[9];
    int   n;

    // Async reset with no clock edge involved.
    #2 rst_n = 1'b0;
    #1;
    check("rst_x", ball_x, SX);
    check("rst_y", ball_y, SY);
    check("rst_state", state, 0);
    check("rst_scores", score_l + score_r, 0);
    check("rst_point", point, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m = reset_model();

    for (int i = 0; i < 5; i++) tbl[i] = '{sv: 1'b0, ex: 316, ey: 236, est: 0};
    tbl[5] = '{sv: 1'b1, ex: 316, ey: 236, est: 1};
    tbl[6] = '{sv: 1'b0, ex: 318, ey: 238, est: 1};
    tbl[7] = '{sv: 1'b1, ex: 320, ey: 240, est: 1};
    tbl[8] = '{sv: 1'b1, ex: 322, ey: 242, est: 1};
    for (int i = 0; i < 9; i++) begin
      fr(tbl[i].sv, 400, 400);
      check("tbl_x", ball_x, tbl[i].ex);
      check("tbl_y", ball_y, tbl[i].ey);
      check("tbl_state", state, tbl[i].est);
    end

    // Bottom wall bounce at y=470 moving down.
    n = 0;
    while (!(m.st == 1 && m.dy > 0 && m.y == 470) && n < 400) begin
      fr(1'b0, far_pad(m.y), track(m.y)); n++;
    end
    check("reach_y470", ball_y, 470);
    fr(1'b0, far_pad(m.y), track(m.y));
    check("wall_y472", ball_y, 472);
    fr(1'b0, far_pad(m.y), track(m.y));
    check("wall_back_y470", ball_y, 470);

    // Left paddle hit from x=26.
    n = 0;
    while (!(m.st == 1 && m.dx < 0 && m.x == 26) && n < 600) begin
      fr(1'b0, far_pad(m.y), track(m.y)); n++;
    end
    check("reach_x26", ball_x, 26);
    fr(1'b0, track(m.y), track(m.y));
    check("lhit_x24", ball_x, 24);
    fr(1'b0, track(m.y), track(m.y));
    check("lhit_back_x26", ball_x, 26);

    // Same approach with no overlap: ball passes to x=0 and misses.
    n = 0;
    while (!(m.st == 1 && m.dx < 0 && m.x == 26) && n < 600) begin
      fr(1'b0, far_pad(m.y), track(m.y)); n++;
    end
    check("reach_x26_again", ball_x, 26);
    fr(1'b0, far_pad(m.y), track(m.y));
    check("nohit_x24", ball_x, 24);
    n = 0;
    while (m.x != 0 && n < 30) begin
      fr(1'b0, far_pad(m.y), track(m.y)); n++;
    end
    check("reach_x0", ball_x, 0);
    fr(1'b0, far_pad(m.y), track(m.y));
    check("miss_score_r", score_r, 1);
    check("miss_state", state, 2);
    check("miss_ball_x", ball_x, SX);
    check("miss_ball_y", ball_y, SY);

    // HOLD lasts exactly 60 ticks and ignores serve.
    for (int i = 0; i < HOLDF - 1; i++) fr(1'b1, 400, 400);
    check("hold_still", state, 2);
    fr(1'b1, 400, 400);
    check("hold_done_state", state, 1);
    check("hold_done_x", ball_x, SX);
    check("hold_done_y", ball_y, SY);
    fr(1'b0, far_pad(m.y), track(m.y));
    check("serve_dir_left_x", ball_x, SX - SPD);

    // Play the right side up to the winning score, then game over and restart.
    n = 0;
    while (m.sr != WIN && n < 3000) begin
      fr(1'b0, far_pad(m.y), track(m.y)); n++;
    end
    check("win_score_r", score_r, WIN);
    check("win_hold", state, 2);
    for (int i = 0; i < HOLDF - 1; i++) fr(1'b1, 400, 400);
    check("win_hold_end", state, 2);
    fr(1'b0, 400, 400);
    check("over_state", state, 3);
    for (int i = 0; i < 3; i++) fr(1'b0, 400, 400);
    check("over_stays", state, 3);
    check("over_score_held", score_r, WIN);
    fr(1'b1, 400, 400);
    check("restart_state", state, 1);
    check("restart_scores", score_l + score_r, 0);

    // Randomized play against the model.
    for (int i = 0; i < 1500; i++) begin
      int pl, pr;
      pl = ($urandom_range(0, 3) != 0) ? clampp(track(m.y) + $urandom_range(0, 60) - 30)
                                       : $urandom_range(0, 479);
      pr = ($urandom_range(0, 3) != 0) ? clampp(track(m.y) + $urandom_range(0, 60) - 30)
                                       : $urandom_range(0, 479);
      fr($urandom_range(0, 3) == 0, pl, pr);
    end

    // Reset in the middle of HOLD.
    n = 0;
    while (m.st != 2 && n < 2000) begin
      fr(m.st != 1, far_pad(m.y), far_pad(m.y)); n++;
    end
    check("reach_hold", state, 2);
    for (int i = 0; i < 30; i++) fr(1'b0, 400, 400);
    check("hold_tick30", state, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_x", ball_x, SX);
    check("midrst_y", ball_y, SY);
    check("midrst_state", state, 0);
    check("midrst_score_l", score_l, 0);
    check("midrst_score_r", score_r, 0);
    check("midrst_point", point, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m = reset_model();
    for (int i = 0; i < 3; i++) fr(1'b0, 400, 400);
    check("post_rst_idle", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
